alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: NREGS, 8, register-file depth; fixed at 8 because indices are 3 bits.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  command present.
REQ-006 in_ready  output  1  sequencer can accept a command.
REQ-007 in_op  input  3  ALU select: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 SUB, 101 SRA, 110 SLL, 111 NOR.
REQ-008 in_rd / in_rs / in_rt  input  3 each  destination, source A and source B register indices.
REQ-009 in_imm_en  input  1  when 1, operand B is in_imm instead of reg[in_rt].
REQ-010 in_imm  input  32  immediate operand B.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 out_result  output  32  ALU result R.
REQ-014 out_rd  output  3  destination index of out_result.
REQ-015 out_of  output  1  ALU overflow flag.
REQ-016 out_z  output  1  ALU zero flag.
REQ-017 dbg_addr  input  3  debug read index.
REQ-018 dbg_data  output  32  combinational read of reg[dbg_addr].

Function
REQ-019 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-020 in_ready SHALL be 1 only in IDLE and SHALL be 0 while rst is high.
REQ-021 Accept (IDLE, in_valid=1): latch op, rd, A=reg[rs] and B=(imm_en ? imm : reg[rt]); go to EXEC.
REQ-022 EXEC: drive the latched A, B and op into the ALU; register R, OF and Z; go to RESP.
REQ-023 RESP: out_valid=1; out_result, out_rd, out_of and out_z SHALL stay stable until out_valid && out_ready.
REQ-024 On out_valid && out_ready: write reg[rd]=out_result unless rd=0; go to IDLE.
REQ-025 The next command SHALL be accepted no earlier than the cycle after the handshake.
REQ-026 Latency SHALL be: result visible 2 cycles after accept; accept-to-accept minimum 3 cycles.
REQ-027 reg[0] SHALL always read 0; writes to rd=0 are dropped, but the response is still issued.
REQ-028 Operand reads SHALL see all writebacks completed before the accept edge (no hazard, since there is a single command in flight).
REQ-029 ALU semantics: SRA and SLL shift A by B[4:0]; SUB is A-B.
REQ-030 OF SHALL equal ADD carry-out or SUB borrow, and SHALL be 0 for every other op.
REQ-031 Z SHALL be 1 iff R==0.
REQ-032 ADD and SUB results SHALL wrap modulo 2^32.
REQ-033 in_valid while in_ready=0 SHALL be ignored; the source holds the command.

Reset
REQ-034 On rst: state=IDLE, all registers=0, out_valid=0, out_result=0, out_rd=0, out_of=0, out_z=0.
REQ-035 Reset during EXEC or RESP SHALL abandon the command with no writeback.
REQ-036 Reset SHALL have priority over every handshake in the same cycle.

Structure
REQ-037 The shared package SHALL hold: the op-code constants (AND..NOR), the state enum, and the REG_IDX_W=3 and DATA_W=32 constants.
REQ-038 The ALU datapath SHALL be the existing alu32 sub-module, instantiated once.
REQ-039 The register file and FSM SHALL be local to alu_sequencer.

Verification
REQ-040 Reset then dbg reads of all 8 indices -> all 0; in_ready=1 the cycle after rst falls.
REQ-041 ADD imm 32'h7FFFFFFF into r1, then ADD r1 + imm 1 into r2 -> r2=32'h80000000, OF=0, Z=0.
REQ-042 ADD 32'hFFFFFFFF + 1 -> result 0, OF=1, Z=1.
REQ-043 SUB 5-7 -> 32'hFFFFFFFE, OF=1.
REQ-044 SRA 32'h80000000 by 4 -> 32'hF8000000, OF=0.
REQ-045 Hold out_ready=0 for 5 cycles in RESP -> outputs stable, in_ready=0, writeback only after the handshake.
REQ-046 Write to rd=0 -> response issued, reg[0] still reads 0.
REQ-047 Assert rst during RESP -> no writeback, out_valid=0 the next cycle.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// Shared constants for the ALU sequencer: widths, ALU op-codes and FSM state encoding.
// Imported by the sequencer top and the alu32 datapath.
package alu_sequencer_pkg;

  localparam int REG_IDX_W = 3;
  localparam int DATA_W    = 32;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SRA = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_NOR = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_sequencer_alu32.sv
// alu32: purely combinational 32-bit ALU, zero latency, no flow control.
// OF is ADD carry-out or SUB borrow and 0 for every other op; Z flags a zero result.
module alu32
  import alu_sequencer_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [2:0]        i_op,
  output logic [DATA_W-1:0] o_r,
  output logic              o_of,
  output logic              o_z
);

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff;

  // 33-bit extension: the top bit is carry for ADD and borrow for SUB
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    o_r  = '0;
    o_of = 1'b0;
    case (i_op)
      OP_AND: o_r = i_a & i_b;
      OP_OR:  o_r = i_a | i_b;
      OP_ADD: begin
        o_r  = w_sum[DATA_W-1:0];
        o_of = w_sum[DATA_W];
      end
      OP_XOR: o_r = i_a ^ i_b;
      OP_SUB: begin
        o_r  = w_diff[DATA_W-1:0];
        o_of = w_diff[DATA_W];
      end
      OP_SRA: o_r = $signed(i_a) >>> i_b[4:0];
      OP_SLL: o_r = i_a << i_b[4:0];
      OP_NOR: o_r = ~(i_a | i_b);
      default: o_r = '0;
    endcase
  end

  assign o_z = (o_r == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Single-command ALU sequencer over an 8x32 register file; result valid 2 cycles after accept.
// Backpressure: result held stable until out_ready; no new command accepted until the cycle after that handshake.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int NREGS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_op,
  input  logic [REG_IDX_W-1:0] in_rd,
  input  logic [REG_IDX_W-1:0] in_rs,
  input  logic [REG_IDX_W-1:0] in_rt,
  input  logic                 in_imm_en,
  input  logic [DATA_W-1:0]    in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_result,
  output logic [REG_IDX_W-1:0] out_rd,
  output logic                 out_of,
  output logic                 out_z,
  input  logic [REG_IDX_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]    dbg_data
);

  state_t                 r_state;
  logic [DATA_W-1:0]      r_regs [NREGS];
  logic [2:0]             r_op;
  logic [REG_IDX_W-1:0]   r_rd;
  logic [DATA_W-1:0]      r_a;
  logic [DATA_W-1:0]      r_b;
  logic [DATA_W-1:0]      r_result;
  logic                   r_of;
  logic                   r_z;

  logic [DATA_W-1:0]      w_rs_val;
  logic [DATA_W-1:0]      w_rt_val;
  logic [DATA_W-1:0]      w_alu_r;
  logic                   w_alu_of;
  logic                   w_alu_z;

  // reg[0] is hard-wired to zero on every read path
  assign w_rs_val = (in_rs == '0)    ? '0 : r_regs[in_rs];
  assign w_rt_val = (in_rt == '0)    ? '0 : r_regs[in_rt];
  assign dbg_data = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];

  assign in_ready   = (r_state == IDLE) && !rst;
  assign out_valid  = (r_state == RESP);
  assign out_result = r_result;
  assign out_rd     = r_rd;
  assign out_of     = r_of;
  assign out_z      = r_z;

  alu32 u_alu (
    .i_a  (r_a),
    .i_b  (r_b),
    .i_op (r_op),
    .o_r  (w_alu_r),
    .o_of (w_alu_of),
    .o_z  (w_alu_z)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_op     <= OP_AND;
      r_rd     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_of     <= 1'b0;
      r_z      <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_op    <= in_op;
            r_rd    <= in_rd;
            r_a     <= w_rs_val;
            r_b     <= in_imm_en ? in_imm : w_rt_val;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_result <= w_alu_r;
          r_of     <= w_alu_of;
          r_z      <= w_alu_z;
          r_state  <= RESP;
        end
        RESP: begin
          // Writeback happens only on the handshake; rd=0 still completes the response
          if (out_ready) begin
            if (r_rd != '0) begin
              r_regs[r_rd] <= r_result;
            end
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: directed corner cases then randomized commands vs. a reference model.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [2:0]  in_rd, in_rs, in_rt;
  logic        in_imm_en;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_rd;
  logic        out_of, out_z;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;

  typedef struct {
    logic [31:0] r;
    logic [2:0]  rd;
    logic        of;
    logic        z;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_regs [8];
  int          errors = 0;
  int          checks = 0;
  bit          hold   = 1'b1;

  always #5 clk = ~clk;

  alu_sequencer #(.NREGS(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
    .in_imm_en(in_imm_en), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_of(out_of), .out_z(out_z),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU written from the arithmetic rules, not the RTL structure
  function automatic void ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic of);
    longint unsigned la, lb, s;
    int sh;
    la = a; lb = b; sh = int'(b[4:0]);
    of = 1'b0;
    r  = 32'h0;
    case (op)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOR: r = ~(a | b);
      OP_ADD: begin s = la + lb; r = s[31:0]; of = (s >= 64'h1_0000_0000); end
      OP_SUB: begin s = la - lb; r = s[31:0]; of = (la < lb); end
      OP_SRA: r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      OP_SLL: r = a << sh;
      default: r = 32'h0;
    endcase
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 8; i++) m_regs[i] = 32'h0;
    sb.delete();
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                       input logic [2:0] rt, input logic ie, input logic [31:0] imm);
    int   n = 0;
    exp_t e;
    logic [31:0] a, b;
    @(posedge clk); #1;
    in_op = op; in_rd = rd; in_rs = rs; in_rt = rt; in_imm_en = ie; in_imm = imm;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", {63'h0, in_ready}, 64'h1);
    if (in_ready) begin
      a = m_regs[rs];
      b = ie ? imm : m_regs[rt];
      ref_alu(op, a, b, e.r, e.of);
      e.z  = (e.r == 32'h0);
      e.rd = rd;
      sb.push_back(e);
      if (rd != 3'd0) m_regs[rd] = e.r;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(sb.size()), 64'h0);
  endtask

  task automatic wait_out_valid();
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_timeout", {63'h0, out_valid}, 64'h1);
  endtask

  task automatic chk_dbg(input string name, input logic [2:0] idx, input logic [31:0] exp);
    dbg_addr = idx;
    #1;
    chk(name, {32'h0, dbg_data}, {32'h0, exp});
  endtask

  // Consumer: random out_ready unless a hold is requested
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks stability while stalled
  initial begin
    logic [37:0] snap, cur;
    bit          have_snap = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        have_snap = 1'b0;
      end else if (out_valid) begin
        chk("in_ready_busy", {63'h0, in_ready}, 64'h0);
        cur = {out_result, out_rd, out_of, out_z};
        if (have_snap) chk("resp_stable", {26'h0, cur}, {26'h0, snap});
        if (out_ready) begin
          have_snap = 1'b0;
          if (sb.size() == 0) begin
            chk("unexpected_resp", {32'h0, out_result}, 64'hDEAD_BEEF_DEAD_BEEF);
          end else begin
            e = sb.pop_front();
            chk("result", {32'h0, out_result}, {32'h0, e.r});
            chk("rd",     {61'h0, out_rd},     {61'h0, e.rd});
            chk("of",     {63'h0, out_of},     {63'h0, e.of});
            chk("z",      {63'h0, out_z},      {63'h0, e.z});
          end
        end else begin
          snap      = cur;
          have_snap = 1'b1;
        end
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old;
    logic [31:0] imm;
    rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_rd = 3'd0; in_rs = 3'd0; in_rt = 3'd0;
    in_imm_en = 1'b0; in_imm = 32'h0; dbg_addr = 3'd0;
    clear_model();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_in_ready",  {63'h0, in_ready},  64'h0);
    chk("rst_outputs",   {26'h0, out_result, out_rd, out_of, out_z}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", {63'h0, in_ready}, 64'h1);
    for (int i = 0; i < 8; i++) chk_dbg("rst_dbg", 3'(i), 32'h0);
    hold = 1'b0;

    // Overflow into sign bit is not a carry
    issue(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 32'h7FFF_FFFF);
    issue(OP_ADD, 3'd2, 3'd1, 3'd0, 1'b1, 32'h1);
    drain();
    chk_dbg("add_r2", 3'd2, 32'h8000_0000);

    // Carry-out wrap to zero, borrow, arithmetic shift
    issue(OP_OR,  3'd3, 3'd0, 3'd0, 1'b1, 32'hFFFF_FFFF);
    issue(OP_ADD, 3'd4, 3'd3, 3'd0, 1'b1, 32'h1);
    issue(OP_OR,  3'd5, 3'd0, 3'd0, 1'b1, 32'd5);
    issue(OP_SUB, 3'd6, 3'd5, 3'd0, 1'b1, 32'd7);
    issue(OP_OR,  3'd7, 3'd0, 3'd0, 1'b1, 32'h8000_0000);
    issue(OP_SRA, 3'd1, 3'd7, 3'd0, 1'b1, 32'd4);
    drain();
    chk_dbg("add_wrap_r4", 3'd4, 32'h0);
    chk_dbg("sub_r6",      3'd6, 32'hFFFF_FFFE);
    chk_dbg("sra_r1",      3'd1, 32'hF800_0000);

    // Stall in RESP: no writeback until the handshake
    old  = m_regs[3];
    hold = 1'b1;
    issue(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 32'h0);
    wait_out_valid();
    for (int i = 0; i < 5; i++) begin
      chk("hold_in_ready", {63'h0, in_ready}, 64'h0);
      chk_dbg("hold_no_wb", 3'd3, old);
      @(negedge clk);
    end
    hold = 1'b0;
    drain();
    chk_dbg("after_hold_r3", 3'd3, m_regs[3]);

    // Writes to r0 still respond but are dropped
    issue(OP_OR, 3'd0, 3'd0, 3'd0, 1'b1, 32'h1234_5678);
    drain();
    chk_dbg("r0_zero", 3'd0, 32'h0);

    // Reset while the response is pending
    hold = 1'b1;
    issue(OP_ADD, 3'd5, 3'd0, 3'd0, 1'b1, 32'h55);
    wait_out_valid();
    @(posedge clk); #1;
    rst = 1'b1;
    clear_model();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_resp_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_resp_in_ready",  {63'h0, in_ready},  64'h1);
    chk_dbg("rst_resp_no_wb", 3'd5, 32'h0);
    hold = 1'b0;

    // Randomized commands
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 5))
        0: imm = 32'h0;
        1: imm = 32'hFFFF_FFFF;
        2: imm = 32'h8000_0000;
        default: imm = $urandom;
      endcase
      issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), imm);
    end
    drain();
    for (int i = 0; i < 8; i++) chk_dbg("final_regs", 3'(i), m_regs[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
